// File: rtl/crc32_stream.sv
// crc32_stream: multi-byte-per-beat CRC-32 engine; beats in (data_in/keep_in/valid_in/sof/eof), frame result out (crc_out/crc_valid/crc_ok), framing errors on protocol_err, busy while a frame is open
module crc32_stream #(
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] POLYNOMIAL = 32'h04C11DB7,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter bit          REFLECT    = 1'b1,
  parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic [DATA_BYTES-1:0]   keep_in,
  input  logic                    valid_in,
  input  logic                    sof,
  input  logic                    eof,
  output logic [31:0]             crc_out,
  output logic                    crc_valid,
  output logic                    crc_ok,
  output logic                    protocol_err,
  output logic                    busy
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  function automatic logic [31:0] rev32(input logic [31:0] v);
    for (int i = 0; i < 32; i++) rev32[i] = v[31-i];
  endfunction
  localparam logic [31:0] POLY_R = rev32(POLYNOMIAL);
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    crc_byte = c;
    for (int i = 0; i < 8; i++)
      crc_byte = REFLECT ? ({1'b0, crc_byte[31:1]} ^ ((crc_byte[0] ^ b[i]) ? POLY_R : 32'h0))
                         : ({crc_byte[30:0], 1'b0} ^ ((crc_byte[31] ^ b[7-i]) ? POLYNOMIAL : 32'h0));
  endfunction
  function automatic logic [31:0] fold_beat(input logic [31:0] c, input logic [8*DATA_BYTES-1:0] d,
                                            input logic [DATA_BYTES-1:0] k);
    fold_beat = c;
    for (int j = 0; j < DATA_BYTES; j++)
      if (k[j]) fold_beat = crc_byte(fold_beat, d[8*j+:8]);
  endfunction
  state_t      state_q, state_d;
  logic [31:0] crc_q, fold;
  logic        keep_ok, accept, err_d;
  always_comb begin
    keep_ok = eof ? (keep_in != '0 && (keep_in & (keep_in + DATA_BYTES'(1))) == '0) : (keep_in == '1);
    accept  = valid_in && keep_ok && (sof || state_q == ACTIVE);
    err_d   = valid_in && (!keep_ok || (state_q == IDLE && !sof) || (state_q == ACTIVE && sof));
    fold    = fold_beat(sof ? INIT : crc_q, data_in, keep_in);
    state_d = !valid_in ? state_q : (accept && !eof) ? ACTIVE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      crc_q        <= INIT;
      crc_out      <= '0;
      crc_valid    <= 1'b0;
      crc_ok       <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_valid    <= accept && eof;
      protocol_err <= err_d;
      if (accept) crc_q <= fold;
      if (accept && eof) begin
        crc_out <= fold ^ XOR_OUT;
        crc_ok  <= fold == RESIDUE;
      end
    end
  end
  assign busy = state_q == ACTIVE;
endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: directed-vector self-checking bench for crc32_stream in reflected 4-byte, 1-byte and non-reflected 2-byte builds
module tb_crc32_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] data4 = '0;
  logic [3:0]  keep4 = '0;
  logic        v4 = 0, sof4 = 0, eof4 = 0;
  logic [31:0] co4;
  logic        cv4, ok4, pe4, busy4;
  logic [7:0]  data1 = '0;
  logic [0:0]  keep1 = '0;
  logic        v1 = 0, sof1 = 0, eof1 = 0;
  logic [31:0] co1;
  logic        cv1, ok1, pe1, busy1;
  logic [15:0] data2 = '0;
  logic [1:0]  keep2 = '0;
  logic        v2 = 0, sof2 = 0, eof2 = 0;
  logic [31:0] co2;
  logic        cv2, ok2, pe2, busy2;
  crc32_stream u_d4 (
    .clk(clk), .rst(rst), .data_in(data4), .keep_in(keep4), .valid_in(v4), .sof(sof4), .eof(eof4),
    .crc_out(co4), .crc_valid(cv4), .crc_ok(ok4), .protocol_err(pe4), .busy(busy4)
  );
  crc32_stream #(.DATA_BYTES(1)) u_d1 (
    .clk(clk), .rst(rst), .data_in(data1), .keep_in(keep1), .valid_in(v1), .sof(sof1), .eof(eof1),
    .crc_out(co1), .crc_valid(cv1), .crc_ok(ok1), .protocol_err(pe1), .busy(busy1)
  );
  crc32_stream #(.DATA_BYTES(2), .REFLECT(1'b0), .XOR_OUT(32'h0)) u_m2 (
    .clk(clk), .rst(rst), .data_in(data2), .keep_in(keep2), .valid_in(v2), .sof(sof2), .eof(eof2),
    .crc_out(co2), .crc_valid(cv2), .crc_ok(ok2), .protocol_err(pe2), .busy(busy2)
  );
  int nv4 = 0, npe4 = 0, nv1 = 0, nv2 = 0;
  logic busy1_seen = 1'b0;
  always @(posedge clk) begin
    if (cv4) nv4 <= nv4 + 1;
    if (pe4) npe4 <= npe4 + 1;
    if (cv1) nv1 <= nv1 + 1;
    if (cv2) nv2 <= nv2 + 1;
    if (busy1) busy1_seen <= 1'b1;
  end
  int n_chk = 0, n_fail = 0;
  int bv, bp;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic beat4(input logic [31:0] d, input logic [3:0] k, input logic s, input logic e);
    data4 = d; keep4 = k; sof4 = s; eof4 = e; v4 = 1'b1;
    @(negedge clk);
  endtask
  task automatic beat1(input logic [7:0] d, input logic s, input logic e);
    data1 = d; keep1 = 1'b1; sof1 = s; eof1 = e; v1 = 1'b1;
    @(negedge clk);
  endtask
  task automatic beat2(input logic [15:0] d, input logic [1:0] k, input logic s, input logic e);
    data2 = d; keep2 = k; sof2 = s; eof2 = e; v2 = 1'b1;
    @(negedge clk);
  endtask
  task automatic idle();
    v4 = 0; sof4 = 0; eof4 = 0; v1 = 0; sof1 = 0; eof1 = 0; v2 = 0; sof2 = 0; eof2 = 0;
    @(negedge clk);
  endtask
  task automatic send_check4();
    beat4(32'h34333231, 4'hF, 1, 0);
    beat4(32'h38373635, 4'hF, 0, 0);
    beat4(32'h00000039, 4'h1, 0, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst crc_out", co4, 32'h0);
    check("rst crc_valid", cv4, 0);
    check("rst crc_ok", ok4, 0);
    check("rst protocol_err", pe4, 0);
    check("rst busy", busy4, 0);
    check("rst d1 crc_out", co1, 32'h0);
    check("rst m2 crc_out", co2, 32'h0);
    rst = 1'b0;
    bv = nv4;
    beat4(32'h34333231, 4'hF, 1, 0);
    check("t1 busy rise", busy4, 1);
    check("t1 no err", pe4, 0);
    beat4(32'h38373635, 4'hF, 0, 0);
    check("t1 no early valid", cv4, 0);
    beat4(32'h00000039, 4'h1, 0, 1);
    check("t1 crc_out", co4, 32'hCBF43926);
    check("t1 crc_valid", cv4, 1);
    check("t1 crc_ok", ok4, 0);
    check("t1 busy fall", busy4, 0);
    idle();
    check("t1 valid pulse", cv4, 0);
    check("t1 crc held", co4, 32'hCBF43926);
    idle();
    check("t1 valid count", nv4 - bv, 1);
    beat4(32'h34333231, 4'hF, 1, 0);
    beat4(32'h38373635, 4'hF, 0, 0);
    beat4(32'hF4392639, 4'hF, 0, 0);
    beat4(32'h000000CB, 4'h1, 0, 1);
    check("t2 crc_out", co4, 32'h2144DF1C);
    check("t2 crc_ok", ok4, 1);
    idle();
    check("t2 crc_ok held", ok4, 1);
    beat1(8'h00, 1, 1);
    check("t3 crc_out", co1, 32'hD202EF8D);
    check("t3 crc_valid", cv1, 1);
    idle();
    idle();
    check("t3 busy never", busy1_seen, 0);
    check("t3 valid count", nv1, 1);
    beat2(16'h3231, 2'b11, 1, 0);
    beat2(16'h3433, 2'b11, 0, 0);
    beat2(16'h3635, 2'b11, 0, 0);
    beat2(16'h3837, 2'b11, 0, 0);
    beat2(16'h0039, 2'b01, 0, 1);
    check("t4 crc_out", co2, 32'h0376E6E7);
    check("t4 crc_valid", cv2, 1);
    idle();
    idle();
    check("t4 valid count", nv2, 1);
    bv = nv4; bp = npe4;
    beat4(32'hDEADBEEF, 4'hF, 1, 0);
    check("t5 A busy", busy4, 1);
    beat4(32'h34333231, 4'hF, 1, 0);
    check("t5 sof abort err", pe4, 1);
    check("t5 busy after restart", busy4, 1);
    beat4(32'h38373635, 4'hF, 0, 0);
    check("t5 err pulse", pe4, 0);
    beat4(32'h00000039, 4'h1, 0, 1);
    check("t5 B crc_out", co4, 32'hCBF43926);
    check("t5 B crc_valid", cv4, 1);
    beat4(32'h34333231, 4'hF, 1, 0);
    check("t5 b2b valid pulse", cv4, 0);
    check("t5 b2b busy", busy4, 1);
    beat4(32'h38373635, 4'hF, 0, 0);
    beat4(32'hF4392639, 4'hF, 0, 0);
    beat4(32'h000000CB, 4'h1, 0, 1);
    check("t5 b2b crc_out", co4, 32'h2144DF1C);
    check("t5 b2b crc_ok", ok4, 1);
    idle();
    idle();
    check("t5 valid count AB", nv4 - bv, 2);
    check("t5 err count A", npe4 - bp, 1);
    beat4(32'h11111111, 4'hF, 0, 0);
    check("t5 nosof err", pe4, 1);
    check("t5 nosof busy", busy4, 0);
    idle();
    check("t5 nosof err pulse", pe4, 0);
    beat4(32'h34333231, 4'hF, 1, 0);
    beat4(32'h38373635, 4'h7, 0, 0);
    check("t5 keep err", pe4, 1);
    check("t5 keep abort busy", busy4, 0);
    idle();
    idle();
    check("t5 valid count end", nv4 - bv, 2);
    check("t5 err count end", npe4 - bp, 3);
    bv = nv4; bp = npe4;
    beat4(32'h34333231, 4'hF, 1, 0);
    beat4(32'h38373635, 4'hF, 0, 0);
    v4 = 0; sof4 = 0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 crc_out", co4, 32'h0);
    check("t6 crc_valid", cv4, 0);
    check("t6 crc_ok", ok4, 0);
    check("t6 protocol_err", pe4, 0);
    check("t6 busy", busy4, 0);
    send_check4();
    check("t6 crc_out new", co4, 32'hCBF43926);
    idle();
    idle();
    check("t6 valid count", nv4 - bv, 1);
    check("t6 err count", npe4 - bp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/crc32_stream.md
# crc32_stream

Parametrised, multi-byte-per-beat CRC engine that supersedes the single-byte Ethernet CRC32 block in the network path. Sits beside the MAC TX/RX datapath: on TX it generates the FCS over a framed byte stream; on RX it checks received frames (data + FCS) against the residue. It accepts `DATA_BYTES` bytes per cycle with a per-lane keep mask, supports reflected and non-reflected CRC-32 variants, and reports protocol errors on malformed framing.

## Interface
- `DATA_BYTES`, 4: bytes per beat. Legal values are 1, 2, 4 and 8.
- `POLYNOMIAL`, 32'h04C11DB7: generator polynomial in normal (MSB-first) notation.
- `INIT`, 32'hFFFFFFFF: register value loaded at frame start.
- `REFLECT`, 1:
  - 1 means each byte is processed LSB-first and the result is reflected (CRC-32/ISO-HDLC, Ethernet).
  - 0 means MSB-first with no reflection.
- `XOR_OUT`, 32'hFFFFFFFF: final XOR applied to `crc_out`.
- `RESIDUE`, 32'hDEBB20E3: expected raw register value (before `XOR_OUT`) after a frame plus its FCS has been processed.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high. All state is updated on `clk` rising edge.
- `data_in`  in  8*DATA_BYTES  beat data. Lane 0 is `[7:0]` and is first on the wire.
- `keep_in`  in  DATA_BYTES  lane-valid mask.
- `valid_in`  in  1  beat qualifier. The block has no backpressure and accepts one beat every cycle.
- `sof`  in  1  first beat of frame. Qualified by `valid_in`.
- `eof`  in  1  last beat of frame. Qualified by `valid_in`.
- `crc_out`  out  32  final CRC (raw register ^ `XOR_OUT`). Held until the next `crc_valid`.
- `crc_valid`  out  1  one-cycle pulse: frame result is valid.
- `crc_ok`  out  1  raw register == `RESIDUE` at `eof`. Valid with `crc_valid` and held with `crc_out`.
- `protocol_err`  out  1  one-cycle pulse on a framing violation.
- `busy`  out  1  high while a frame is open (state ACTIVE).

## Operation
- **States:** IDLE and ACTIVE. Reset forces IDLE.
- **Accepted beat.** A beat is accepted when `valid_in` is high and the beat is legal. An accepted beat folds its enabled lanes into the register in lane order 0 up to `DATA_BYTES`-1. The update is fully unrolled combinationally, so one beat is processed per cycle.
- **sof beat.** The register is seeded with `INIT` and the beat is then processed in the same cycle.
- **Transitions:**
  - IDLE with sof and not eof: go to ACTIVE.
  - IDLE with sof and eof: single-beat frame; stay in IDLE and produce a result.
  - ACTIVE with eof: result produced; return to IDLE.
- **keep_in rules:**
  - Non-eof beats must have all lanes set.
  - The eof beat must be contiguous from lane 0 and non-zero (for example 0001, 0011, 0111, 1111).
- **Framing violations.** Each violation pulses `protocol_err` for one cycle:
  - valid_in without sof in IDLE: beat dropped; stay in IDLE.
  - sof while ACTIVE: the old frame is aborted with no `crc_valid`; the new frame restarts from `INIT` using this beat.
  - Illegal `keep_in` on any beat: beat dropped; frame aborted; go to IDLE. No `crc_valid` is produced for that frame.
- **Ignored inputs:** `sof` and `eof` are ignored when `valid_in` is low.
- **Result register.** The result register (`crc_out`, `crc_ok`) is separate from the running register. This allows the next frame's sof on the cycle immediately after eof with no bubble.

## Timing
- **Reset values:** `crc_out`=0, `crc_valid`=0, `crc_ok`=0, `protocol_err`=0, `busy`=0, running register = `INIT`.
- **Reset mid-frame:** the frame is discarded. No `crc_valid` or `protocol_err` is produced for it.
- **Result latency:** an eof beat accepted at edge N produces `crc_valid`=1 in the cycle after edge N, with `crc_out` and `crc_ok` updated at that same edge.
- **protocol_err latency:** registered, asserted in the cycle after the offending beat.
- **busy:** rises the cycle after an accepted non-eof sof and falls the cycle after eof or abort.
- **Throughput:** 1 beat per cycle, with back-to-back frames (eof at N, sof at N+1) sustained indefinitely.

## Test plan
1. **Default CRC, three beats.**
   - Stimulus: defaults, DATA_BYTES=4, ASCII "123456789" as beats "1234" (sof), "5678", "9" with keep 0001 (eof).
   - Required: one `crc_valid` pulse with `crc_out`=32'hCBF43926 and `crc_ok`=0.
2. **FCS check.**
   - Stimulus: same 9 bytes followed by FCS bytes 26 39 F4 CB. Beats are "1234", "5678", {'9',26,39,F4}, then {CB} with keep 0001 (eof).
   - Required: `crc_ok`=1 and `crc_out`=32'h2144DF1C.
3. **Single byte, sof+eof on one beat.**
   - Stimulus: DATA_BYTES=1, byte 8'h00 with sof=eof=1.
   - Required: `crc_out`=32'hD202EF8D one cycle later; `busy` never asserts.
4. **Non-reflected mode.**
   - Stimulus: REFLECT=0, XOR_OUT=0, DATA_BYTES=2, "123456789" with keep 01 on the eof beat.
   - Required: `crc_out`=32'h0376E6E7 (CRC-32/MPEG-2).
5. **Abort, recovery and back-to-back.** One sequence covers:
   - Frame A is interrupted by a new sof. Required: `protocol_err` pulse; no result for A.
   - Frame B ("123456789") follows. Required: `crc_out`=32'hCBF43926.
   - The next frame's sof arrives on the cycle immediately after B's eof. Required: its result is correct.
   - A beat with valid_in and no sof in IDLE, and a non-eof beat with keep 0111. Required: each produces one `protocol_err` pulse and no `crc_valid`.
6. **Reset mid-frame.**
   - Stimulus: assert `rst` for one cycle after two beats of a frame, then send "123456789".
   - Required: all outputs are at their reset values the cycle after reset. The aborted frame produces no `crc_valid`; the new frame gives 32'hCBF43926.
